// File: rtl/conv2d_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_layer_seq
// Brief    : Single-channel KxK convolution engine, KERNEL_NUM kernels in
//            parallel, loadable image/weight/bias memories, strided anchors.
//            Optional macro CONV_RELU_EN clamps negative results to zero.
// Revision : 1.0 - initial release
// ============================================================================
module conv2d_layer_seq #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_WIDTH   = 40,
    parameter int ADDR_WIDTH  = 16,
    parameter int KERNEL_NUM  = 6,
    parameter int KERNEL_SIZE = 5,
    parameter int MAP_WIDTH   = 35,
    parameter int MAP_HEIGHT  = 35,
    parameter int STRIDE      = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             layer_enable,
    input  logic                             img_wr_en,
    input  logic [ADDR_WIDTH-1:0]            img_wr_addr,
    input  logic [DATA_WIDTH-1:0]            img_wr_data,
    input  logic                             w_wr_en,
    input  logic [ADDR_WIDTH-1:0]            w_wr_addr,
    input  logic [DATA_WIDTH-1:0]            w_wr_data,
    input  logic                             b_wr_en,
    input  logic [ADDR_WIDTH-1:0]            b_wr_addr,
    input  logic [DATA_WIDTH-1:0]            b_wr_data,
    output logic [KERNEL_NUM*DATA_WIDTH-1:0] out_bus,
    output logic [ADDR_WIDTH-1:0]            out_addr,
    output logic                             out_wr_en,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             done
);

    localparam int OUT_W     = (MAP_WIDTH - KERNEL_SIZE) / STRIDE + 1;
    localparam int OUT_H     = (MAP_HEIGHT - KERNEL_SIZE) / STRIDE + 1;
    localparam int TAPS      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int TAP_W     = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int KW        = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int IMG_DEPTH = MAP_WIDTH * MAP_HEIGHT;
    localparam int IMG_AW    = (IMG_DEPTH > 1) ? $clog2(IMG_DEPTH) : 1;
    localparam int W_DEPTH   = KERNEL_NUM * TAPS;
    localparam int W_AW      = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
    localparam int B_AW      = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
    localparam int PROD_W    = 2 * DATA_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] IMG_LIMIT = ADDR_WIDTH'(IMG_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] W_LIMIT   = ADDR_WIDTH'(W_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] B_LIMIT   = ADDR_WIDTH'(KERNEL_NUM);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [TAP_W-1:0]                tap_q, tap_d;
    logic [KW-1:0]                   tx_q, tx_d, ty_q, ty_d;
    logic [IMG_AW-1:0]               ox_q, ox_d, oy_q, oy_d;
    logic [IMG_AW-1:0]               win_x_q, win_x_d, win_y_q, win_y_d;
    logic [ADDR_WIDTH-1:0]           out_addr_q, out_addr_d;
    logic                            out_wr_en_q, out_wr_en_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            rd_vld_q, rd_vld_d;
    logic [TAP_W-1:0]                rd_tap_q, rd_tap_d;
    logic signed [DATA_WIDTH-1:0]    img_rd_q, img_rd_d;
    logic [KERNEL_NUM*DATA_WIDTH-1:0] out_bus_q, out_bus_d;
    logic [KERNEL_NUM*DATA_WIDTH-1:0] result_bus;
    logic [IMG_AW-1:0]               rd_addr;

    logic signed [DATA_WIDTH-1:0] img_mem [2**IMG_AW];
    logic signed [DATA_WIDTH-1:0] w_mem   [2**W_AW];
    logic signed [DATA_WIDTH-1:0] b_mem   [2**B_AW];

    // Loading is frozen while a layer is in flight so the map stays coherent.
    always_ff @(posedge clk) begin
        if (!busy_q) begin
            if (img_wr_en && (img_wr_addr < IMG_LIMIT))
                img_mem[img_wr_addr[IMG_AW-1:0]] <= img_wr_data;
            if (w_wr_en && (w_wr_addr < W_LIMIT))
                w_mem[w_wr_addr[W_AW-1:0]] <= w_wr_data;
            if (b_wr_en && (b_wr_addr < B_LIMIT))
                b_mem[b_wr_addr[B_AW-1:0]] <= b_wr_data;
        end
    end

    assign rd_addr = (win_y_q + IMG_AW'(ty_q)) * IMG_AW'(MAP_WIDTH)
                   + win_x_q + IMG_AW'(tx_q);

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        out_addr_d  = out_addr_q;
        out_wr_en_d = out_wr_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_vld_d    = 1'b0;
        rd_tap_d    = tap_q;
        img_rd_d    = img_mem[rd_addr];
        out_bus_d   = out_bus_q;

        case (state_q)
            S_IDLE: begin
                if (layer_enable) begin
                    state_d    = S_MAC;
                    busy_d     = 1'b1;
                    tap_d      = '0;
                    tx_d       = '0;
                    ty_d       = '0;
                    ox_d       = '0;
                    oy_d       = '0;
                    win_x_d    = '0;
                    win_y_d    = '0;
                    out_addr_d = '0;
                end
            end
            S_MAC: begin
                rd_vld_d = 1'b1;
                if (tap_q == TAP_W'(TAPS - 1)) begin
                    state_d = S_DRAIN;
                    tap_d   = '0;
                    tx_d    = '0;
                    ty_d    = '0;
                end else begin
                    tap_d = tap_q + 1'b1;
                    if (tx_q == KW'(KERNEL_SIZE - 1)) begin
                        tx_d = '0;
                        ty_d = ty_q + 1'b1;
                    end else begin
                        tx_d = tx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                state_d     = S_OUT;
                out_wr_en_d = 1'b1;
                out_bus_d   = result_bus;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_wr_en_d = 1'b0;
                    if (ox_q == IMG_AW'(OUT_W - 1)) begin
                        ox_d    = '0;
                        win_x_d = '0;
                        if (oy_q == IMG_AW'(OUT_H - 1)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            oy_d    = oy_q + 1'b1;
                            win_y_d = win_y_q + IMG_AW'(STRIDE);
                        end
                    end else begin
                        ox_d    = ox_q + 1'b1;
                        win_x_d = win_x_q + IMG_AW'(STRIDE);
                    end
                    if (!((ox_q == IMG_AW'(OUT_W - 1)) && (oy_q == IMG_AW'(OUT_H - 1)))) begin
                        state_d    = S_MAC;
                        out_addr_d = out_addr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            win_x_q     <= '0;
            win_y_q     <= '0;
            out_addr_q  <= '0;
            out_wr_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_tap_q    <= '0;
            img_rd_q    <= '0;
            out_bus_q   <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
            out_addr_q  <= out_addr_d;
            out_wr_en_q <= out_wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_vld_q    <= rd_vld_d;
            rd_tap_q    <= rd_tap_d;
            img_rd_q    <= img_rd_d;
            out_bus_q   <= out_bus_d;
        end
    end

    // One MAC lane per kernel; tap 0 data seeds the accumulator with the bias.
    for (genvar j = 0; j < KERNEL_NUM; j++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] tap_weight;
        logic signed [DATA_WIDTH-1:0] bias;
        logic signed [PROD_W-1:0]     prod;
        logic signed [ACC_WIDTH-1:0]  prod_ext;
        logic signed [ACC_WIDTH-1:0]  bias_ext;
        logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
        logic signed [ACC_WIDTH-1:0]  shifted;
        logic signed [DATA_WIDTH-1:0] sat;
        logic signed [DATA_WIDTH-1:0] res;

        assign tap_weight = w_mem[W_AW'(j * TAPS) + W_AW'(rd_tap_q)];
        assign bias       = b_mem[B_AW'(j)];
        assign prod       = PROD_W'(img_rd_q) * PROD_W'(tap_weight);
        assign prod_ext   = ACC_WIDTH'(prod);
        assign bias_ext   = ACC_WIDTH'(bias) <<< FRAC_BITS;

        always_comb begin
            acc_d = acc_q;
            if (rd_vld_q)
                acc_d = ((rd_tap_q == '0) ? bias_ext : acc_q) + prod_ext;
            shifted = acc_d >>> FRAC_BITS;
            if (shifted > SAT_MAX)
                sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            else if (shifted < SAT_MIN)
                sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            else
                sat = shifted[DATA_WIDTH-1:0];
`ifdef CONV_RELU_EN
            res = sat[DATA_WIDTH-1] ? '0 : sat;
`else
            res = sat;
`endif
        end

        always_ff @(posedge clk) begin
            if (rst)
                acc_q <= '0;
            else
                acc_q <= acc_d;
        end

        assign result_bus[j*DATA_WIDTH +: DATA_WIDTH] = res;
    end

    assign out_bus   = out_bus_q;
    assign out_addr  = out_addr_q;
    assign out_wr_en = out_wr_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: doc/conv2d_layer_seq.md
Name: conv2d_layer_seq

Overview:
Parametrised single-input-channel convolution layer engine, successor to the fixed 35x35 / 5x5 / 6-kernel first conv stage.
- Holds one input feature map in an internal buffer; kernel weights and biases are loaded through write ports rather than a fixed ROM.
- Sequentially MACs each KxK window against all KERNEL_NUM kernels in parallel, with configurable stride.
- Emits one KERNEL_NUM-wide result word per anchor to the pooling stage, with out_ready backpressure and busy/done status.

Parameters:
DATA_WIDTH, 16, signed fixed-point sample/weight/output width
FRAC_BITS, 8, fractional bits of data and weights
ACC_WIDTH, 40, signed accumulator width
ADDR_WIDTH, 16, width of all address ports
KERNEL_NUM, 6, kernels computed in parallel
KERNEL_SIZE, 5, kernel side K
MAP_WIDTH, 35, input map width
MAP_HEIGHT, 35, input map height
STRIDE, 1, anchor step in x and y

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
layer_enable  in  1  start pulse; sampled in IDLE only
img_wr_en  in  1  image buffer write strobe
img_wr_addr  in  ADDR_WIDTH  raster address y*MAP_WIDTH+x
img_wr_data  in  DATA_WIDTH  sample
w_wr_en  in  1  weight write strobe
w_wr_addr  in  ADDR_WIDTH  kernel*K*K + tap (tap raster within the kernel)
w_wr_data  in  DATA_WIDTH  weight
b_wr_en  in  1  bias write strobe
b_wr_addr  in  ADDR_WIDTH  kernel index
b_wr_data  in  DATA_WIDTH  bias (same Q format as data)
out_bus  out  KERNEL_NUM*DATA_WIDTH  kernel j result in bits [DW*(j+1)-1:DW*j]
out_addr  out  ADDR_WIDTH  output raster index oy*OUT_W+ox
out_wr_en  out  1  out_bus/out_addr valid
out_ready  in  1  downstream accepts when high together with out_wr_en
busy  out  1  high from start until done
done  out  1  one-cycle pulse after the last output is accepted

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. On rst: state IDLE, out_bus=0, out_addr=0, out_wr_en=0, busy=0, done=0, accumulators=0.
- Memory contents are not cleared by reset.
- Output grid: OUT_W=(MAP_WIDTH-K)/STRIDE+1, OUT_H=(MAP_HEIGHT-K)/STRIDE+1 (integer division).
- Anchor order: raster, ox fastest. Window origin is (ox*STRIDE, oy*STRIDE).
- Write ports:
  - Accepted only when busy=0; ignored otherwise.
  - Addresses out of range are ignored.
  - A write coincident with an accepted layer_enable is accepted (it precedes the start).
- State machine:
  - IDLE: busy=0. On layer_enable go to MAC, busy=1, anchor=(0,0), out_addr=0.
  - MAC (K*K cycles): cycle t issues the image read for tap t (1-cycle read latency). Accumulators are initialised to bias<<FRAC_BITS when tap 0 data returns; each tap adds img*w[j][t] (full 2*DATA_WIDTH product, sign-extended to ACC_WIDTH).
  - DRAIN (1 cycle): adds the final tap.
  - OUT: out_wr_en=1; out_bus and out_addr are held stable until out_ready=1.
    - On accept with more anchors: next anchor, out_addr+1, go to MAC; out_wr_en drops for the MAC period.
    - On accept of the last anchor: go to DONE.
  - DONE (1 cycle): done=1, busy=0 next, return to IDLE.
- Throughput: with out_ready held high, each anchor takes exactly K*K+2 cycles from MAC entry to the accept cycle.
- Result arithmetic: acc>>>FRAC_BITS (arithmetic shift), saturated to signed DATA_WIDTH range [-2^(DW-1), 2^(DW-1)-1], then the optional ReLU.
- layer_enable while busy: ignored.
- out_ready high outside OUT: no effect.
- Reset mid-operation: immediate return to IDLE with reset outputs; the next layer_enable restarts at anchor 0.

Optional Feature:
CONV_RELU_EN
- Defined: each saturated result that is negative is output as 0.
- Undefined: the signed saturated result passes unchanged.

Test Plan:
(All with DW=16, FRAC=8, MAP 6x6, K=3, STRIDE=1, KERNEL_NUM=2; write rate and timing as stated.)
1. Image all 0x0100, kernel0 all 0x0100, bias0 0x0080, out_ready=1 -> 16 outputs, out_addr 0..15, lane0=0x0980 each; accept cycles spaced 11 apart; done 1 cycle after the 16th accept.
2. Kernel1 all 0xFF00, bias1 0 -> lane1=0x0000 with CONV_RELU_EN; 0xF700 without.
3. Image all 0x7FFF, kernel0 all 0x7FFF -> lane0=0x7FFF (positive saturation). Kernel0 all 0x8000 without CONV_RELU_EN -> lane0=0x8000.
4. out_ready low for 5 cycles at anchor 3 -> out_wr_en stays high, out_bus/out_addr=3 stable, then accepted; no address skipped; total run extended by exactly 5 cycles.
5. STRIDE=2, image = x+8*y in Q8.8, kernel0 = single tap (0,0)=0x0100 -> 4 outputs at addresses 0..3 equal to pixels (0,0),(2,0),(0,2),(2,2) = 0,2,16,18 (Q8.8).
6. rst asserted on the 4th MAC cycle of anchor 5 -> next cycle out_wr_en=0, busy=0, out_addr=0. Re-enable -> full 16-output run matching scenario 1; an img_wr_en issued while busy leaves the results unchanged.
